output_shaper: RTL and testbench
================================

// Module: output_shaper
//
// PURPOSE
//   Counterpart of the input conditioner on the output side: takes single-cycle
//   rise/fall request pulses and rebuilds a clean level output with a minimum dwell time.
//   Every level change is held at least HOLDCYCLES clocks, so it is glitch-free.
//   One pending request is queued while the hold runs.
//   Drives LEDs, enables and handshake lines from the pulses logic produces.
//
// PARAMETERS
//   HOLDCYCLES    3   minimum clocks driven must stay stable after a change (>=1)
//   COUNTERWIDTH  3   width of dwell counter; must hold HOLDCYCLES-1
//
// PORTS
//   clk           input   1  system clock, all state updates on rising edge
//   rst_n         input   1  asynchronous, active-low reset
//   positiveedge  input   1  one-cycle request: drive output high
//   negativeedge  input   1  one-cycle request: drive output low
//   driven        output  1  shaped level output (registered)
//   busy          output  1  high while the dwell window is running (HOLD state)
//   pending       output  1  high while a queued toggle waits for the dwell window to end
//   dropped       output  1  one-cycle pulse when a request is discarded as ambiguous
//
// BEHAVIOUR
//   - Reset (rst_n=0, async): driven=0, busy=0, pending=0, dropped=0, count=0, state=IDLE.
//     Takes effect immediately, including mid-hold. Any queued request is lost.
//   - Request: req_hi = positiveedge & ~negativeedge; req_lo = negativeedge & ~positiveedge.
//   - Both inputs high in the same cycle: the request is ignored and dropped=1 for one cycle.
//     State, driven and pending are unchanged.
//   - A request is "effective" when it targets the opposite of the current driven level.
//     A request equal to the current level is a no-op.
//   - IDLE, effective request sampled at edge k: driven flips after edge k (latency 1).
//     count=0 and state goes to HOLD.
//   - HOLD, at each edge:
//       - count != HOLDCYCLES-1: count increments.
//       - Effective request: sets pending=1. A repeat while pending=1 changes nothing.
//       - Request equal to the current level: clears pending (cancel).
//       - count == HOLDCYCLES-1: end of dwell, driven has been stable HOLDCYCLES clocks.
//         - If pending=1 (after applying this edge's request): driven flips, pending=0,
//           count=0, stay in HOLD.
//         - Otherwise: state goes to IDLE, count=0.
//   - Result: one request at edge k with no follow-up gives driven changed from edge k,
//     busy=1 after edges k..k+HOLDCYCLES-1, and busy=0 after edge k+HOLDCYCLES.
//   - HOLDCYCLES=1: HOLD lasts one clock; alternating requests every cycle toggle driven
//     every cycle.
//   - Counter never wraps: it resets to 0 at the end of the dwell.
//   - busy = (state==HOLD); pending and dropped are registered.
//
// TESTING (HOLDCYCLES=3)
//   1. Reset, then idle 5 cycles -> driven=0 busy=0 pending=0 dropped=0 throughout.
//   2. positiveedge pulse at edge 1 -> driven=1 after edge 1; busy=1 after edges 1..3;
//      busy=0 after edge 4; driven stays 1.
//   3. positiveedge at edge 1, negativeedge at edge 2 -> pending=1 after edge 2;
//      driven=0 after edge 4; busy=0 after edge 7.
//   4. positiveedge at edge 1, negativeedge at edge 2, positiveedge at edge 3
//      -> pending cleared after edge 3; driven stays 1; busy=0 after edge 4.
//   5. Both inputs high at edge 1 while idle -> dropped=1 for one cycle only;
//      driven=0 and busy=0 unchanged. Repeat while driven=1 and idle -> positiveedge
//      alone is ignored (no busy).
//   6. rst_n low asynchronously mid-HOLD with pending=1 -> all outputs 0 immediately;
//      after release, a negativeedge is ignored (driven already 0).

Source files
------------

// File: rtl/output_shaper.sv
// output_shaper: rebuilds a glitch-free level from rise/fall request pulses.
//
// Each change of the output level is held for at least HOLDCYCLES clocks.
// While the hold runs, one opposite-level request can be queued. A request
// for the level already being driven cancels that queued request.
//
// Ports:
//   clk           system clock, rising edge
//   rst_n         asynchronous active-low reset
//   positiveedge  one-cycle request to drive the output high
//   negativeedge  one-cycle request to drive the output low
//   driven        shaped level output (registered)
//   busy          high while the dwell window runs
//   pending       high while a queued toggle waits for the dwell to end
//   dropped       one-cycle pulse when both requests arrive together
module output_shaper #(
    parameter int HOLDCYCLES   = 3,
    parameter int COUNTERWIDTH = 3
) (
    input  logic clk,
    input  logic rst_n,
    input  logic positiveedge,
    input  logic negativeedge,
    output logic driven,
    output logic busy,
    output logic pending,
    output logic dropped
);
    typedef enum logic {IDLE, HOLD} state_t;

    localparam logic [COUNTERWIDTH-1:0] LAST = COUNTERWIDTH'(HOLDCYCLES - 1);

    state_t                  state_q, state_d;
    logic [COUNTERWIDTH-1:0] count_q, count_d;
    logic                    driven_q, driven_d;
    logic                    pending_q, pending_d;
    logic                    dropped_q, dropped_d;
    logic                    req_hi, req_lo, eff, same, pend;

    // Simultaneous requests are ambiguous, so they count as no request at all.
    assign req_hi = positiveedge & ~negativeedge;
    assign req_lo = negativeedge & ~positiveedge;
    assign eff    = driven_q ? req_lo : req_hi;
    assign same   = driven_q ? req_hi : req_lo;
    // This is the queued state once the request on this edge has been applied.
    assign pend   = eff | (pending_q & ~same);

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        driven_d  = driven_q;
        pending_d = pending_q;
        dropped_d = positiveedge & negativeedge;
        if (state_q == IDLE) begin
            driven_d = eff ? ~driven_q : driven_q;
            state_d  = eff ? HOLD : IDLE;
            count_d  = '0;
        end else if (count_q == LAST) begin
            driven_d  = pend ? ~driven_q : driven_q;
            state_d   = pend ? HOLD : IDLE;
            count_d   = '0;
            pending_d = 1'b0;
        end else begin
            count_d   = count_q + 1'b1;
            pending_d = pend;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            count_q   <= '0;
            driven_q  <= 1'b0;
            pending_q <= 1'b0;
            dropped_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            driven_q  <= driven_d;
            pending_q <= pending_d;
            dropped_q <= dropped_d;
        end
    end

    assign driven  = driven_q;
    assign busy    = (state_q == HOLD);
    assign pending = pending_q;
    assign dropped = dropped_q;
endmodule

// File: tb/tb_output_shaper.sv
// tb_output_shaper: directed scoreboard bench for output_shaper (HOLDCYCLES=3).
module tb_output_shaper;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic positiveedge = 1'b0;
    logic negativeedge = 1'b0;
    logic driven, busy, pending, dropped;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic d;
        logic b;
        logic p;
        logic dr;
    } exp_t;

    exp_t sb[$];

    output_shaper #(.HOLDCYCLES(3), .COUNTERWIDTH(3)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .positiveedge(positiveedge),
        .negativeedge(negativeedge),
        .driven(driven),
        .busy(busy),
        .pending(pending),
        .dropped(dropped)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_all(input string tag, input exp_t e);
        chk({tag, ".driven"}, driven, e.d);
        chk({tag, ".busy"}, busy, e.b);
        chk({tag, ".pending"}, pending, e.p);
        chk({tag, ".dropped"}, dropped, e.dr);
    endtask

    // Drive one cycle of requests, queue the state the outputs must show after
    // the next rising edge, then pop it and compare once that edge has passed.
    task automatic step(input string tag, input logic pe, input logic ne, input logic [3:0] e);
        @(negedge clk);
        positiveedge = pe;
        negativeedge = ne;
        sb.push_back(exp_t'(e));
        @(posedge clk);
        #1;
        positiveedge = 1'b0;
        negativeedge = 1'b0;
        check_all(tag, sb.pop_front());
    endtask

    initial begin
        // 1. reset and idle
        repeat (2) @(posedge clk);
        #1;
        check_all("reset", exp_t'(4'b0000));
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) step("idle", 1'b0, 1'b0, 4'b0000);
        // 2. single rise: busy for three edges, then idle with level held
        step("t2.e1", 1'b1, 1'b0, 4'b1100);
        step("t2.e2", 1'b0, 1'b0, 4'b1100);
        step("t2.e3", 1'b0, 1'b0, 4'b1100);
        step("t2.e4", 1'b0, 1'b0, 4'b1000);
        step("t2.e5", 1'b0, 1'b0, 4'b1000);
        // return to low
        step("ret1.e1", 1'b0, 1'b1, 4'b0100);
        step("ret1.e2", 1'b0, 1'b0, 4'b0100);
        step("ret1.e3", 1'b0, 1'b0, 4'b0100);
        step("ret1.e4", 1'b0, 1'b0, 4'b0000);
        // 3. queued fall during the hold
        step("t3.e1", 1'b1, 1'b0, 4'b1100);
        step("t3.e2", 1'b0, 1'b1, 4'b1110);
        step("t3.e3", 1'b0, 1'b0, 4'b1110);
        step("t3.e4", 1'b0, 1'b0, 4'b0100);
        step("t3.e5", 1'b0, 1'b0, 4'b0100);
        step("t3.e6", 1'b0, 1'b0, 4'b0100);
        step("t3.e7", 1'b0, 1'b0, 4'b0000);
        // 4. queued fall cancelled by a same-level rise
        step("t4.e1", 1'b1, 1'b0, 4'b1100);
        step("t4.e2", 1'b0, 1'b1, 4'b1110);
        step("t4.e3", 1'b1, 1'b0, 4'b1100);
        step("t4.e4", 1'b0, 1'b0, 4'b1000);
        step("t4.e5", 1'b0, 1'b0, 4'b1000);
        // return to low
        step("ret2.e1", 1'b0, 1'b1, 4'b0100);
        step("ret2.e2", 1'b0, 1'b0, 4'b0100);
        step("ret2.e3", 1'b0, 1'b0, 4'b0100);
        step("ret2.e4", 1'b0, 1'b0, 4'b0000);
        // 5. ambiguous requests are dropped; same-level request is a no-op
        step("t5.both_lo", 1'b1, 1'b1, 4'b0001);
        step("t5.after_lo", 1'b0, 1'b0, 4'b0000);
        step("t5.rise", 1'b1, 1'b0, 4'b1100);
        step("t5.h2", 1'b0, 1'b0, 4'b1100);
        step("t5.h3", 1'b0, 1'b0, 4'b1100);
        step("t5.h4", 1'b0, 1'b0, 4'b1000);
        step("t5.both_hi", 1'b1, 1'b1, 4'b1001);
        step("t5.same_hi", 1'b1, 1'b0, 4'b1000);
        step("t5.after_hi", 1'b0, 1'b0, 4'b1000);
        // 6. asynchronous reset mid-hold with a queued toggle
        step("t6.fall", 1'b0, 1'b1, 4'b0100);
        step("t6.queue", 1'b1, 1'b0, 4'b0110);
        #2;
        rst_n = 1'b0;
        #1;
        check_all("t6.async_rst", exp_t'(4'b0000));
        @(negedge clk);
        rst_n = 1'b1;
        step("t6.neg_noop", 1'b0, 1'b1, 4'b0000);
        step("t6.after", 1'b0, 1'b0, 4'b0000);
        chk("sb_empty", sb.size() == 0, 1'b1);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
